aes_key_schedule: RTL and testbench



---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_subword.sv | 20 ++
 rtl/aes_key_schedule.sv | 164 ++++++++++++++++
 tb/tb_aes_key_schedule.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the key schedule and the round FSM.
//   - Key-size mode encodings (MODE_*)
//   - Key schedule state type (ksState_t)
//   - nk_of / nr_of : key length in words and round count for a mode
//   - xtime         : multiply by x in GF(2^8), used to step rcon
//   - sbox          : forward AES S-box
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [1:0] MODE_AES128   = 2'b00;
    localparam logic [1:0] MODE_AES192   = 2'b01;
    localparam logic [1:0] MODE_AES256   = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_READY  = 2'b10
    } ksState_t;

    // Cipher key length in 32-bit words (Nk).
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        logic [3:0] nk;
        case (mode)
            MODE_AES128: nk = 4'd4;
            MODE_AES192: nk = 4'd6;
            default:     nk = 4'd8;
        endcase
        return nk;
    endfunction

    // Number of rounds (Nr).
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            MODE_AES128: nr = 4'd10;
            MODE_AES192: nr = 4'd12;
            default:     nr = 4'd14;
        endcase
        return nr;
    endfunction

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// ---------------------------------------------------------------------------
// aes_subword
// Applies the AES S-box to each byte of a 32-bit word (SubWord).
// Ports:
//   i_word  in  32  input word
//   o_word  out 32  byte-wise substituted word
// ---------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word[31:24] = sbox(i_word[31:24]);
    assign o_word[23:16] = sbox(i_word[23:16]);
    assign o_word[15:8]  = sbox(i_word[15:8]);
    assign o_word[7:0]   = sbox(i_word[7:0]);

endmodule

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
// Word-serial AES-128/192/256 key expansion with round-key storage.
// A load writes the cipher key words and then one schedule word is produced
// per cycle. Once complete, 128-bit round keys are served combinationally by
// round index, optionally in reverse (decryption) order.
// Ports:
//   clk           in  1    rising-edge clock
//   reset         in  1    synchronous active-high reset
//   mode          in  2    key size, sampled on load (00/01/10, 11 reserved)
//   key_in        in  256  cipher key, MSB-aligned
//   load          in  1    start expansion
//   rk_idx        in  4    requested round index
//   rk_inv        in  1    1 = serve round Nr-rk_idx
//   round_key     out 128  selected round key (0 when invalid)
//   key_valid     out 1    schedule complete
//   busy          out 1    expansion in progress
//   round_amount  out 4    Nr of stored schedule
//   mode_err      out 1    sticky reserved-mode load flag
// ---------------------------------------------------------------------------
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    input  logic         load,
    input  logic [3:0]   rk_idx,
    input  logic         rk_inv,
    output logic [127:0] round_key,
    output logic         key_valid,
    output logic         busy,
    output logic [3:0]   round_amount,
    output logic         mode_err
);

    ksState_t    r_state;
    ksState_t    w_nextState;

    logic [31:0] r_w [0:59];
    logic [3:0]  r_nk;
    logic [3:0]  r_nr;
    logic [5:0]  r_i;
    logic [2:0]  r_j;
    logic [7:0]  r_rcon;
    logic        r_modeErr;

    logic        w_loadValid;
    logic [3:0]  w_loadNk;
    logic [5:0]  w_lastIdx;
    logic        w_jWrap;
    logic [31:0] w_prevWord;
    logic [31:0] w_oldWord;
    logic [31:0] w_subIn;
    logic [31:0] w_subOut;
    logic [31:0] w_temp;
    logic [31:0] w_newWord;
    logic [3:0]  w_effIdx;

    assign w_loadValid = load && (mode != MODE_RESERVED);
    assign w_loadNk    = nk_of(mode);
    // Index of the final schedule word, 4*Nr+3, formed without an adder.
    assign w_lastIdx   = {r_nr, 2'b11};
    assign w_jWrap     = ({1'b0, r_j} == (r_nk - 4'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a valid load always (re)starts the expansion.
    always_comb begin
        w_nextState = r_state;
        if (w_loadValid) begin
            w_nextState = ST_EXPAND;
        end else if ((r_state == ST_EXPAND) && (r_i == w_lastIdx)) begin
            w_nextState = ST_READY;
        end
    end

    // Expansion datapath: the word Nk back and the previous word.
    assign w_prevWord = r_w[r_i - 6'd1];
    assign w_oldWord  = r_w[r_i - {2'b00, r_nk}];
    assign w_subIn    = (r_j == 3'd0) ? {w_prevWord[23:0], w_prevWord[31:24]} : w_prevWord;

    aes_subword u_subword (
        .i_word (w_subIn),
        .o_word (w_subOut)
    );

    // Temp word: RotWord/SubWord/rcon at the start of each Nk group, and the
    // extra SubWord mid-group that only AES-256 uses.
    always_comb begin
        w_temp = w_prevWord;
        if (r_j == 3'd0) begin
            w_temp = w_subOut ^ {r_rcon, 24'h000000};
        end else if ((r_nk == 4'd8) && (r_j == 3'd4)) begin
            w_temp = w_subOut;
        end
        w_newWord = w_oldWord ^ w_temp;
    end

    // Schedule storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_loadValid) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_loadNk) begin
                    r_w[k] <= key_in[255 - 32*k -: 32];
                end
            end
        end else if (r_state == ST_EXPAND) begin
            r_w[r_i] <= w_newWord;
        end
    end

    // Control counters and mode registers. j tracks i mod Nk by wrapping,
    // and rcon advances once per Nk group.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nk      <= 4'd4;
            r_nr      <= 4'hA;
            r_i       <= 6'd0;
            r_j       <= 3'd0;
            r_rcon    <= 8'h01;
            r_modeErr <= 1'b0;
        end else if (load && (mode == MODE_RESERVED)) begin
            r_modeErr <= 1'b1;
        end else if (w_loadValid) begin
            r_nk   <= w_loadNk;
            r_nr   <= nr_of(mode);
            r_i    <= {2'b00, w_loadNk};
            r_j    <= 3'd0;
            r_rcon <= 8'h01;
        end else if (r_state == ST_EXPAND) begin
            r_i <= r_i + 6'd1;
            r_j <= w_jWrap ? 3'd0 : (r_j + 3'd1);
            if (r_j == 3'd0) begin
                r_rcon <= xtime(r_rcon);
            end
        end
    end

    // Round key read: combinational from rk_idx/rk_inv, zero when out of
    // range or when no complete schedule is stored.
    always_comb begin
        w_effIdx  = rk_inv ? (r_nr - rk_idx) : rk_idx;
        round_key = '0;
        if ((r_state == ST_READY) && (rk_idx <= r_nr)) begin
            round_key = {r_w[{w_effIdx, 2'b00}], r_w[{w_effIdx, 2'b01}],
                         r_w[{w_effIdx, 2'b10}], r_w[{w_effIdx, 2'b11}]};
        end
    end

    assign key_valid    = (r_state == ST_READY);
    assign busy         = (r_state == ST_EXPAND);
    assign round_amount = r_nr;
    assign mode_err     = r_modeErr;

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
// Directed bench for aes_key_schedule using FIPS-197 key expansion vectors.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

    logic         clk;
    logic         reset;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         load;
    logic [3:0]   rk_idx;
    logic         rk_inv;
    logic [127:0] round_key;
    logic         key_valid;
    logic         busy;
    logic [3:0]   round_amount;
    logic         mode_err;

    int checkCount;
    int errorCount;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes_key_schedule dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .key_in       (key_in),
        .load         (load),
        .rk_idx       (rk_idx),
        .rk_inv       (rk_inv),
        .round_key    (round_key),
        .key_valid    (key_valid),
        .busy         (busy),
        .round_amount (round_amount),
        .mode_err     (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Pulse load for one cycle; returns at the negedge after the load edge.
    task automatic applyStimulus(input logic [1:0] m, input logic [255:0] k);
        @(negedge clk);
        mode   = m;
        key_in = k;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Counts cycles from the load edge until key_valid, and how many of
    // those cycles showed busy. Bounded so a stuck DUT still terminates.
    task automatic waitKeyValid(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (!key_valid && cycles < 200) begin
            if (busy) busyCycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic readRoundKey(input logic [3:0] idx, input logic inv,
                                output logic [127:0] rk);
        @(negedge clk);
        rk_idx = idx;
        rk_inv = inv;
        #1;
        rk = round_key;
    endtask

    initial begin
        int cyc;
        int busyCyc;
        logic [127:0] rk;

        checkCount = 0;
        errorCount = 0;
        reset  = 1'b1;
        load   = 1'b0;
        mode   = 2'b00;
        key_in = '0;
        rk_idx = 4'd0;
        rk_inv = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy",      128'(busy),         128'd0);
        checkOutput("rst_valid",     128'(key_valid),    128'd0);
        checkOutput("rst_mode_err",  128'(mode_err),     128'd0);
        checkOutput("rst_round_amt", 128'(round_amount), 128'hA);
        checkOutput("rst_round_key", round_key,          128'd0);
        @(negedge clk);
        reset = 1'b0;

        // AES-128
        applyStimulus(2'b00, KEY128);
        checkOutput("a128_busy_start", 128'(busy), 128'd1);
        waitKeyValid(cyc, busyCyc);
        checkOutput("a128_latency", 128'(cyc), 128'd40);
        checkOutput("a128_busy_cycles", 128'(busyCyc), 128'd40);
        checkOutput("a128_busy_done", 128'(busy), 128'd0);
        checkOutput("a128_round_amt", 128'(round_amount), 128'd10);
        readRoundKey(4'd10, 1'b0, rk);
        checkOutput("a128_rk10", rk, RK128_10);
        readRoundKey(4'd0, 1'b0, rk);
        checkOutput("a128_rk0", rk, RK128_0);
        readRoundKey(4'd10, 1'b1, rk);
        checkOutput("a128_inv10", rk, RK128_0);
        readRoundKey(4'd0, 1'b1, rk);
        checkOutput("a128_inv0", rk, RK128_10);
        readRoundKey(4'd11, 1'b0, rk);
        checkOutput("a128_rk11_oor", rk, 128'd0);

        // Reserved mode: flag only, schedule untouched
        applyStimulus(2'b11, KEY256);
        #1;
        checkOutput("err_mode_err", 128'(mode_err), 128'd1);
        checkOutput("err_valid", 128'(key_valid), 128'd1);
        checkOutput("err_busy", 128'(busy), 128'd0);
        checkOutput("err_round_amt", 128'(round_amount), 128'd10);
        readRoundKey(4'd10, 1'b0, rk);
        checkOutput("err_rk10", rk, RK128_10);

        // AES-192
        applyStimulus(2'b01, KEY192);
        checkOutput("a192_valid_drop", 128'(key_valid), 128'd0);
        waitKeyValid(cyc, busyCyc);
        checkOutput("a192_latency", 128'(cyc), 128'd46);
        checkOutput("a192_round_amt", 128'(round_amount), 128'd12);
        readRoundKey(4'd12, 1'b0, rk);
        checkOutput("a192_rk12", rk, RK192_12);
        readRoundKey(4'd13, 1'b0, rk);
        checkOutput("a192_rk13_oor", rk, 128'd0);

        // AES-256
        applyStimulus(2'b10, KEY256);
        waitKeyValid(cyc, busyCyc);
        checkOutput("a256_latency", 128'(cyc), 128'd52);
        checkOutput("a256_round_amt", 128'(round_amount), 128'd14);
        readRoundKey(4'd14, 1'b0, rk);
        checkOutput("a256_rk14", rk, RK256_14);
        readRoundKey(4'd0, 1'b1, rk);
        checkOutput("a256_inv0", rk, RK256_14);
        readRoundKey(4'd0, 1'b0, rk);
        checkOutput("a256_rk0", rk, KEY256[255:128]);
        readRoundKey(4'd15, 1'b0, rk);
        checkOutput("a256_rk15_oor", rk, 128'd0);

        // Abort: AES-128 load 10 cycles after an AES-256 load
        applyStimulus(2'b10, KEY256);
        repeat (8) @(negedge clk);
        checkOutput("abort_busy_mid", 128'(busy), 128'd1);
        applyStimulus(2'b00, KEY128);
        waitKeyValid(cyc, busyCyc);
        checkOutput("abort_latency", 128'(cyc), 128'd40);
        checkOutput("abort_round_amt", 128'(round_amount), 128'd10);
        checkOutput("abort_mode_err_sticky", 128'(mode_err), 128'd1);
        readRoundKey(4'd10, 1'b0, rk);
        checkOutput("abort_rk10", rk, RK128_10);

        // Reset 20 cycles into an expansion
        applyStimulus(2'b10, KEY256);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        rk_idx = 4'd0;
        rk_inv = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_busy", 128'(busy), 128'd0);
        checkOutput("mid_rst_valid", 128'(key_valid), 128'd0);
        checkOutput("mid_rst_mode_err", 128'(mode_err), 128'd0);
        checkOutput("mid_rst_round_amt", 128'(round_amount), 128'hA);
        checkOutput("mid_rst_round_key", round_key, 128'd0);

        // Load and reset together: reset wins
        @(negedge clk);
        mode   = 2'b01;
        key_in = KEY192;
        load   = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("ld_rst_busy", 128'(busy), 128'd0);
        checkOutput("ld_rst_round_amt", 128'(round_amount), 128'hA);
        repeat (2) @(negedge clk);
        checkOutput("ld_rst_idle", 128'(busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
